// File: rtl/adc_xy_pixel_writer.sv
// ADC X/Y beam sampler: scales raw samples to screen coordinates and queues framebuffer writes.
// Optional build macro ADC_XY_DEDUP_EN suppresses pushes identical to the last pushed entry.
`timescale 1ns/1ps
module adc_xy_pixel_writer #(
  parameter int ADC_DATA_WIDTH  = 10,
  parameter int H_VISIBLE       = 640,
  parameter int V_VISIBLE       = 480,
  parameter int COLOR_WIDTH     = 4,
  parameter int ADDR_WIDTH      = 19,
  parameter int DATA_WIDTH      = 16,
  parameter int FIFO_DEPTH_LOG2 = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic [ADC_DATA_WIDTH-1:0] adc_x,
  input  logic [ADC_DATA_WIDTH-1:0] adc_y,
  input  logic                      adc_red,
  input  logic                      adc_grn,
  input  logic                      adc_blu,
  output logic                      wr_valid,
  input  logic                      wr_ready,
  output logic [ADDR_WIDTH-1:0]     wr_addr,
  output logic [DATA_WIDTH-1:0]     wr_data,
  output logic [15:0]               drop_cnt
);

  localparam int COL_W   = $clog2(H_VISIBLE);
  localparam int ROW_W   = $clog2(V_VISIBLE);
  localparam int XP_W    = ADC_DATA_WIDTH + COL_W;
  localparam int YP_W    = ADC_DATA_WIDTH + ROW_W;
  localparam int DEPTH   = 1 << FIFO_DEPTH_LOG2;
  localparam int CNT_W   = FIFO_DEPTH_LOG2 + 1;
  localparam int ENTRY_W = ADDR_WIDTH + DATA_WIDTH;

  // S1: raw capture
  logic                      r_s1_valid;
  logic [ADC_DATA_WIDTH-1:0] r_s1_x;
  logic [ADC_DATA_WIDTH-1:0] r_s1_y;
  logic [2:0]                r_s1_rgb;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_x     <= '0;
      r_s1_y     <= '0;
      r_s1_rgb   <= '0;
    end else begin
      r_s1_valid <= en;
      r_s1_x     <= adc_x;
      r_s1_y     <= adc_y;
      r_s1_rgb   <= {adc_red, adc_grn, adc_blu};
    end
  end

  // S2: scale to screen; the shift is the only truncation, so results stay in range
  logic [XP_W-1:0]  w_x_prod;
  logic [YP_W-1:0]  w_y_prod;
  logic [COL_W-1:0] w_col;
  logic [ROW_W-1:0] w_yv;
  logic [ROW_W-1:0] w_row;

  assign w_x_prod = XP_W'(r_s1_x) * XP_W'(H_VISIBLE);
  assign w_y_prod = YP_W'(r_s1_y) * YP_W'(V_VISIBLE);
  assign w_col    = COL_W'(w_x_prod >> ADC_DATA_WIDTH);
  assign w_yv     = ROW_W'(w_y_prod >> ADC_DATA_WIDTH);
  assign w_row    = ROW_W'(V_VISIBLE - 1) - w_yv;

  logic             r_s2_valid;
  logic [COL_W-1:0] r_s2_col;
  logic [ROW_W-1:0] r_s2_row;
  logic [2:0]       r_s2_rgb;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid <= 1'b0;
      r_s2_col   <= '0;
      r_s2_row   <= '0;
      r_s2_rgb   <= '0;
    end else begin
      r_s2_valid <= r_s1_valid && (r_s1_rgb != 3'b000);
      r_s2_col   <= w_col;
      r_s2_row   <= w_row;
      r_s2_rgb   <= r_s1_rgb;
    end
  end

  // S3: linear address and replicated colour
  logic [ADDR_WIDTH-1:0]  w_addr;
  logic [DATA_WIDTH-1:0]  w_data;
  logic [COLOR_WIDTH-1:0] w_r;
  logic [COLOR_WIDTH-1:0] w_g;
  logic [COLOR_WIDTH-1:0] w_b;

  assign w_addr = ADDR_WIDTH'(r_s2_row) * ADDR_WIDTH'(H_VISIBLE) + ADDR_WIDTH'(r_s2_col);
  assign w_r    = {COLOR_WIDTH{r_s2_rgb[2]}};
  assign w_g    = {COLOR_WIDTH{r_s2_rgb[1]}};
  assign w_b    = {COLOR_WIDTH{r_s2_rgb[0]}};
  assign w_data = DATA_WIDTH'({w_r, w_g, w_b});

  logic                  r_s3_valid;
  logic [ADDR_WIDTH-1:0] r_s3_addr;
  logic [DATA_WIDTH-1:0] r_s3_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s3_valid <= 1'b0;
      r_s3_addr  <= '0;
      r_s3_data  <= '0;
    end else begin
      r_s3_valid <= r_s2_valid;
      r_s3_addr  <= w_addr;
      r_s3_data  <= w_data;
    end
  end

  // Output FIFO, first-word fall-through
  logic [ENTRY_W-1:0]         r_mem [DEPTH];
  logic [FIFO_DEPTH_LOG2-1:0] r_wr_ptr;
  logic [FIFO_DEPTH_LOG2-1:0] r_rd_ptr;
  logic [CNT_W-1:0]           r_count;
  logic [15:0]                r_drop_cnt;
  logic                       w_dup;
  logic                       w_full;
  logic                       w_pop;
  logic                       w_push_req;
  logic                       w_push;
  logic                       w_drop;

`ifdef ADC_XY_DEDUP_EN
  logic               r_last_valid;
  logic [ENTRY_W-1:0] r_last;

  assign w_dup = r_last_valid && (r_last == {r_s3_addr, r_s3_data});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_valid <= 1'b0;
      r_last       <= '0;
    end else if (w_push) begin
      r_last_valid <= 1'b1;
      r_last       <= {r_s3_addr, r_s3_data};
    end
  end
`else
  assign w_dup = 1'b0;
`endif

  assign w_full     = (r_count == CNT_W'(DEPTH));
  assign w_pop      = wr_valid && wr_ready;
  assign w_push_req = r_s3_valid && !w_dup;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts
  assign w_push     = w_push_req && (!w_full || w_pop);
  assign w_drop     = w_push_req && w_full && !w_pop;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {r_s3_addr, r_s3_data};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_drop_cnt <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_drop && (r_drop_cnt != 16'hFFFF)) begin
        r_drop_cnt <= r_drop_cnt + 16'd1;
      end
    end
  end

  assign wr_valid = (r_count != '0);
  assign wr_addr  = wr_valid ? r_mem[r_rd_ptr][ENTRY_W-1:DATA_WIDTH] : '0;
  assign wr_data  = wr_valid ? r_mem[r_rd_ptr][DATA_WIDTH-1:0] : '0;
  assign drop_cnt = r_drop_cnt;

endmodule
